// File: rtl/semi_auto_motion_executor_pkg.sv
// ---------------------------------------------------------------------
// semi_auto_pkg : state encoding and default timings for motion execution
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

package semi_auto_pkg;

  localparam int STATE_W               = 3;
  localparam int DEFAULT_TURN_CYCLES   = 1000;
  localparam int DEFAULT_SETTLE_CYCLES = 500;
  localparam int DEFAULT_CNT_W         = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_SETTLE = 3'd4
  } motion_state_e;

endpackage

`default_nettype wire

// File: rtl/semi_auto_motion_executor_if.sv
// ---------------------------------------------------------------------
// semi_auto_motion_executor_if : decision inputs and drive outputs
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

interface semi_auto_motion_executor_if;
  logic       move_forward_signal;
  logic       turn_left_signal;
  logic       turn_right_signal;
  logic       front_detector;
  logic       drive_forward;
  logic       drive_left;
  logic       drive_right;
  logic       busy;
  logic       turn_done;
  logic [2:0] motion_state;

  modport master (
    output move_forward_signal, turn_left_signal, turn_right_signal, front_detector,
    input  drive_forward, drive_left, drive_right, busy, turn_done, motion_state
  );

  modport slave (
    input  move_forward_signal, turn_left_signal, turn_right_signal, front_detector,
    output drive_forward, drive_left, drive_right, busy, turn_done, motion_state
  );
endinterface

`default_nettype wire

// File: rtl/semi_auto_motion_executor_timer.sv
// ---------------------------------------------------------------------
// motion_timer : up-counter with clear, enable and terminal-count flag
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

module motion_timer #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clear,
  input  wire logic             en,
  input  wire logic [CNT_W-1:0] compare,
  output logic                  tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = (count_q == compare);

  // Holds at the compare value so a missed clear can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/semi_auto_motion_executor.sv
// ---------------------------------------------------------------------
// semi_auto_motion_executor : turns semi-auto decisions into timed drive commands
// Revision: 1.0
// ---------------------------------------------------------------------
`default_nettype none

module semi_auto_motion_executor
  import semi_auto_pkg::*;
#(
  parameter int TURN_CYCLES   = DEFAULT_TURN_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  semi_auto_motion_executor_if.slave  bus
);

  localparam logic [CNT_W-1:0] TURN_CMP   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_CMP = CNT_W'(SETTLE_CYCLES - 1);

  motion_state_e    state_q, state_d;
  logic             drive_forward_q, drive_forward_d;
  logic             drive_left_q, drive_left_d;
  logic             drive_right_q, drive_right_d;
  logic             busy_q, busy_d;
  logic             turn_done_q, turn_done_d;
  logic             timer_clear, timer_en, timer_tc;
  logic             in_turn;
  logic [CNT_W-1:0] timer_cmp;

  assign in_turn   = (state_q == ST_TURN_L) || (state_q == ST_TURN_R);
  assign timer_cmp = in_turn ? TURN_CMP : SETTLE_CMP;

  motion_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .en      (timer_en),
    .compare (timer_cmp),
    .tc      (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    turn_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.turn_left_signal)                                  state_d = ST_TURN_L;
        else if (bus.turn_right_signal)                            state_d = ST_TURN_R;
        else if (bus.move_forward_signal && !bus.front_detector)   state_d = ST_FWD;
      end
      ST_FWD: begin
        // Obstacle wins over any new decision while driving forward.
        if (bus.front_detector)          state_d = ST_IDLE;
        else if (bus.turn_left_signal)   state_d = ST_TURN_L;
        else if (bus.turn_right_signal)  state_d = ST_TURN_R;
        else if (!bus.move_forward_signal) state_d = ST_IDLE;
      end
      ST_TURN_L, ST_TURN_R: begin
        if (timer_tc) begin
          state_d     = ST_SETTLE;
          turn_done_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (bus.front_detector || timer_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    timer_clear = (state_d != state_q);
    timer_en    = in_turn || (state_q == ST_SETTLE);

    // Outputs follow the next state so they change on the same edge as state.
    drive_forward_d = (state_d == ST_FWD) || (state_d == ST_SETTLE);
    drive_left_d    = (state_d == ST_TURN_L);
    drive_right_d   = (state_d == ST_TURN_R);
    busy_d          = (state_d == ST_TURN_L) || (state_d == ST_TURN_R) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      drive_forward_q <= 1'b0;
      drive_left_q    <= 1'b0;
      drive_right_q   <= 1'b0;
      busy_q          <= 1'b0;
      turn_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      drive_forward_q <= drive_forward_d;
      drive_left_q    <= drive_left_d;
      drive_right_q   <= drive_right_d;
      busy_q          <= busy_d;
      turn_done_q     <= turn_done_d;
    end
  end

  assign bus.drive_forward = drive_forward_q;
  assign bus.drive_left    = drive_left_q;
  assign bus.drive_right   = drive_right_q;
  assign bus.busy          = busy_q;
  assign bus.turn_done     = turn_done_q;
  assign bus.motion_state  = state_q;

endmodule

`default_nettype wire

// File: doc/semi_auto_motion_executor.md
Name: semi_auto_motion_executor

Overview:
- Downstream of the semi-auto decision stage. Consumes its level signals move_forward_signal, turn_left_signal and turn_right_signal.
- Turns each decision into a timed motion on the car's drive outputs:
  - a turn is held for exactly TURN_CYCLES;
  - after a turn, the car drives forward for SETTLE_CYCLES so it clears the junction.
- Decision inputs are ignored while a timed motion is in progress.
- A front obstacle always has priority and stops forward motion immediately.

Parameters:
- TURN_CYCLES, 1000, clock cycles the turn output is held for one 90-degree turn (>=1).
- SETTLE_CYCLES, 500, clock cycles of forced forward drive after a turn completes (>=1).
- CNT_W, 16, counter width; must satisfy 2^CNT_W > max(TURN_CYCLES, SETTLE_CYCLES).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- move_forward_signal  in  1  decision: go straight.
- turn_left_signal  in  1  decision: turn left.
- turn_right_signal  in  1  decision: turn right.
- front_detector  in  1  1 = obstacle ahead.
- drive_forward  out  1  forward motor command (registered).
- drive_left  out  1  left-turn command (registered).
- drive_right  out  1  right-turn command (registered).
- busy  out  1  1 while in TURN_L, TURN_R or SETTLE.
- turn_done  out  1  one-cycle pulse on the cycle a turn finishes (TURN_* -> SETTLE).
- motion_state  out  3  current state encoding.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0;
  - all drive_* = 0, busy = 0, turn_done = 0, motion_state = IDLE.
  - Reset asserted mid-turn or mid-settle aborts immediately, with no completion pulse.
- States and encoding: IDLE=0, FWD=1, TURN_L=2, TURN_R=3, SETTLE=4. All outputs are registered.
- Decision priority when several decision inputs are 1 in the same cycle: turn_left > turn_right > move_forward.
- IDLE:
  - turn_left_signal -> TURN_L;
  - else turn_right_signal -> TURN_R;
  - else move_forward_signal & !front_detector -> FWD;
  - else stay in IDLE.
- FWD:
  - drive_forward=1;
  - front_detector=1 -> IDLE (drive_forward is 0 from the next cycle);
  - a turn decision preempts forward motion using the same priority as IDLE;
  - move_forward_signal=0 with no turn decision -> IDLE.
- TURN_L / TURN_R:
  - drive_left or drive_right = 1, busy=1;
  - counter loads 0 on entry and increments each cycle;
  - when counter == TURN_CYCLES-1: go to SETTLE, pulse turn_done, counter reloads 0.
  - The turn output is high for exactly TURN_CYCLES consecutive cycles.
  - Decision inputs and front_detector are ignored during a turn.
- SETTLE:
  - drive_forward=1, busy=1;
  - counts to SETTLE_CYCLES-1, then -> IDLE;
  - front_detector=1 aborts to IDLE on the next edge; counter is cleared; no pulse is issued.
- Latency: a decision sampled at edge N produces its drive_* output visible after edge N (registered, one cycle).
- Exactly one drive_* output is high at any time, or none.
- Counter:
  - saturating comparison against a constant, never wraps in normal operation;
  - an unused state encoding (5-7) returns to IDLE with outputs 0.

Decomposition:
- Shared package semi_auto_pkg holds:
  - the state encoding constants (IDLE..SETTLE, width 3);
  - the default TURN_CYCLES and SETTLE_CYCLES values, shared with the decision stage and top level.
- One natural sub-module: motion_timer.
  - Contents: CNT_W up-counter with load/clear and terminal-count output, parameterised by compare value.
  - One instance serves both turn and settle phases, with the compare value selected by state.

Test Plan:
- Reset mid-turn: rst_n=0 for 3 cycles, then start a left turn and assert rst_n=0 at cycle 5 of the turn -> all outputs 0 immediately, state=0 after release, no turn_done.
- Forward then obstacle: move_forward_signal=1, front_detector=0 -> drive_forward=1 one cycle later; raise front_detector -> drive_forward=0 on the following cycle, state=IDLE.
- Right turn timing with TURN_CYCLES=8, SETTLE_CYCLES=4: a 1-cycle turn_right_signal pulse produces:
  - drive_right high for exactly 8 cycles;
  - turn_done pulse on the transition;
  - drive_forward high for 4 cycles;
  - then IDLE with busy=0.
- Priority: turn_left_signal=turn_right_signal=move_forward_signal=1 in the same cycle -> drive_left=1, state=2.
- Ignore during turn: toggle turn_left_signal and front_detector during TURN_R -> drive_right duration still 8 cycles; no state change until terminal count.
- Settle abort: front_detector=1 at settle cycle 2 -> IDLE the next cycle, drive_forward=0, turn_done not re-pulsed.
